slave_range_access: RTL and testbench
=====================================

# slave_range_access

Parametrised slave-side access qualifier for a contiguous window of NUM_WORDS word registers starting at BASE_ADDR. It registers a bus request that hits the window and presents a one-hot per-word qualified request plus the decoded word index. It generates the qualified acknowledge either immediately or from an external ack, with an optional ack-timeout that forces an error completion so the bus never hangs. It sits between the register-bus slave interface and a bank of register/peripheral words.

## Interface
- ADDR_WIDTH, 16: word address width (word, not byte, address).
- BASE_ADDR, 16'd0: first word address of the window.
- NUM_WORDS, 4: number of consecutive words decoded; 1..256.
- NEED_EXTERNAL_ACK, 0: 0 = ack in the first qualified cycle; 1 = ack waits for external_ack.
- ACK_TIMEOUT, 16: max qualified cycles without external_ack before error completion; 0 disables. Ignored when NEED_EXTERNAL_ACK=0.
- IDX_WIDTH: local, max(1, clog2(NUM_WORDS)).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- address  in  ADDR_WIDTH  word address, valid with request.
- request  in  1  bus request.
- ack_comb  in  1  combined bus ack from all slaves; ends the current access.
- abort  in  1  bus abort; ends the current access without ack.
- external_ack  in  1  completion from the addressed word's logic.
- qualified_req  out  NUM_WORDS  one-hot registered request, bit i = word BASE_ADDR+i.
- qualified_idx  out  IDX_WIDTH  registered word index (address-BASE_ADDR).
- qualified_ack  out  1  ack toward the bus (combinational from state).
- timeout_err  out  1  one-cycle pulse, coincident with the forced qualified_ack on timeout.
- busy  out  1  high while in REQ.

## Operation
- Hit: BASE_ADDR <= address < BASE_ADDR+NUM_WORDS. Compare in ADDR_WIDTH+1 bits so that windows touching the top of the address space do not wrap. BASE_ADDR+NUM_WORDS > 2^ADDR_WIDTH is an elaboration error.
- FSM states: IDLE, REQ.
- IDLE -> REQ when request && hit && !ack_comb && !abort. On this transition, capture idx = address-BASE_ADDR and clear the wait counter. Otherwise stay in IDLE.
- In REQ:
  - qualified_req = 1<<idx.
  - busy = 1.
  - qualified_ack = 1 if NEED_EXTERNAL_ACK=0; otherwise qualified_ack = external_ack | timeout_err.
- timeout_err = REQ && NEED_EXTERNAL_ACK && ACK_TIMEOUT!=0 && !external_ack && cnt==ACK_TIMEOUT-1.
- Wait counter: increments each REQ cycle without ack; saturates; width clog2(ACK_TIMEOUT+1).
- REQ -> IDLE when ack_comb, abort, or timeout_err. Abort takes priority; no ack is generated in the cycle that follows.
- In IDLE, qualified_req, qualified_idx, qualified_ack, timeout_err and busy are all 0. qualified_idx holds 0 in IDLE.
- A request held high after completion must see IDLE for one cycle before it can re-qualify. This gives a minimum 2-cycle spacing between back-to-back accesses.
- Misses never leave IDLE and produce no outputs.
- Reset: state=IDLE, counter=0. All outputs are 0 in the cycle after rst is sampled high, including reset asserted mid-access; no ack is emitted.

## Timing
- Request sampled at edge N -> qualified_req/qualified_idx valid from N+1.
- Immediate mode: qualified_ack is high at N+1.
- External mode: qualified_ack is high in the same cycle as external_ack (0-cycle combinational path). On timeout, the ack is forced in the ACK_TIMEOUT-th REQ cycle.
- qualified_req drops in the cycle after ack_comb/abort/timeout is sampled.
- external_ack outside REQ is ignored.
- ack_comb and abort together: treated as abort (return to IDLE).

## Test plan
- NUM_WORDS=4, BASE_ADDR=0x10, immediate: request with address=0x12 at cycle 0 -> cycle 1: qualified_req=4'b0100, idx=2, ack=1. ack_comb=1 at cycle 1 -> cycle 2: all outputs 0.
- Miss: address=0x14 and 0x0F -> no output ever asserts. BASE_ADDR=0xFFFC, address=0x0000 -> no hit (no wrap).
- External ack: address=0x11, external_ack at 3rd REQ cycle -> qualified_req=4'b0010 for 3 cycles, ack=1 only in cycle 3, timeout_err=0.
- Timeout: ACK_TIMEOUT=4, no external_ack -> REQ cycle 4 has qualified_ack=1 and timeout_err=1; the next cycle is IDLE.
- Abort on the 2nd REQ cycle with external_ack=1 -> the ack shows that cycle, the FSM returns to IDLE next cycle, and no re-qualification occurs while the held request is sampled with abort high.
- Reset mid-access: rst=1 during REQ -> next cycle all outputs 0. After release, a new hit qualifies normally with the counter restarted from 0.

Source files
------------

// File: rtl/slave_range_access_if.sv
`default_nettype none
// ============================================================================
// Module      : slave_range_access_if
// Description : Register-bus slave port for slave_range_access. It carries the
//               bus request side (address, request, ack_comb, abort), the
//               word-side completion (external_ack), and the qualified outputs
//               toward the word bank and the bus.
//   master modport : bus / word-bank side; drives the request and ack inputs,
//                    observes the qualified outputs
//   slave modport  : slave_range_access side
// Revision    : 1.0 - initial release
// ============================================================================
interface slave_range_access_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int NUM_WORDS  = 4
);
    localparam int IDX_WIDTH = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    logic [ADDR_WIDTH-1:0] address;
    logic                  request;
    logic                  ack_comb;
    logic                  abort;
    logic                  external_ack;
    logic [NUM_WORDS-1:0]  qualified_req;
    logic [IDX_WIDTH-1:0]  qualified_idx;
    logic                  qualified_ack;
    logic                  timeout_err;
    logic                  busy;

    modport master (
        output address, request, ack_comb, abort, external_ack,
        input  qualified_req, qualified_idx, qualified_ack, timeout_err, busy
    );

    modport slave (
        input  address, request, ack_comb, abort, external_ack,
        output qualified_req, qualified_idx, qualified_ack, timeout_err, busy
    );
endinterface
`default_nettype wire

// File: rtl/slave_range_access.sv
`default_nettype none
// ============================================================================
// Module      : slave_range_access
// Description : Slave-side access qualifier for a window of NUM_WORDS word
//               registers starting at word address BASE_ADDR. A bus request
//               that hits the window is registered and presented as a one-hot
//               per-word request plus the word index. The acknowledge is either
//               immediate or taken from external_ack, with an optional timeout
//               that forces an error completion so the bus cannot hang.
// Ports       :
//   clk                 rising-edge clock
//   rst                 synchronous, active-high reset
//   bus.address         word address, valid with request
//   bus.request         bus request
//   bus.ack_comb        combined bus ack; ends the current access
//   bus.abort           bus abort; ends the current access without ack
//   bus.external_ack    completion from the addressed word's logic
//   bus.qualified_req   one-hot registered request, bit i = word BASE_ADDR+i
//   bus.qualified_idx   registered word index (address - BASE_ADDR)
//   bus.qualified_ack   ack toward the bus
//   bus.timeout_err     one-cycle pulse alongside a forced (timeout) ack
//   bus.busy            high while an access is being qualified
// Revision    : 1.0 - initial release
// ============================================================================
module slave_range_access #(
    parameter int                    ADDR_WIDTH        = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR         = '0,
    parameter int                    NUM_WORDS         = 4,
    parameter int                    NEED_EXTERNAL_ACK = 0,
    parameter int                    ACK_TIMEOUT       = 16
) (
    input  wire logic           clk,
    input  wire logic           rst,
    slave_range_access_if.slave bus
);

    localparam int IDX_WIDTH = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int CNT_WIDTH = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;

    // Window bounds carried one bit wider than the address so a window that
    // ends exactly at the top of the address space does not wrap to zero.
    localparam logic [ADDR_WIDTH:0] c_win_lo = {1'b0, BASE_ADDR};
    localparam logic [ADDR_WIDTH:0] c_win_hi = c_win_lo + (ADDR_WIDTH + 1)'(NUM_WORDS);

    localparam logic [0:0] c_st_idle = 1'b0;
    localparam logic [0:0] c_st_req  = 1'b1;

    // ------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------
    generate
        if (NUM_WORDS < 1 || NUM_WORDS > 256) begin : g_bad_num_words
            $error("slave_range_access: NUM_WORDS must be in 1..256");
        end
        if ((64'(BASE_ADDR) + 64'(NUM_WORDS)) > (64'd1 << ADDR_WIDTH)) begin : g_bad_window
            $error("slave_range_access: window extends past the top of the address space");
        end
    endgenerate

    logic [0:0]           r_state;
    logic [0:0]           w_state_nxt;
    logic [NUM_WORDS-1:0] r_req;
    logic [IDX_WIDTH-1:0] r_idx;
    logic [ADDR_WIDTH:0]  w_addr_ext;
    logic                 w_hit;
    logic [IDX_WIDTH-1:0] w_idx;
    logic                 w_busy;
    logic                 w_start;
    logic                 w_done;
    logic                 w_timeout;

    assign w_addr_ext = {1'b0, bus.address};
    assign w_hit      = (w_addr_ext >= c_win_lo) && (w_addr_ext < c_win_hi);
    assign w_idx      = IDX_WIDTH'(bus.address - BASE_ADDR);
    assign w_busy     = (r_state == c_st_req);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            c_st_idle: begin
                // A request still held after a completion re-qualifies only
                // from here, which enforces one IDLE cycle between accesses.
                if (bus.request && w_hit && !bus.ack_comb && !bus.abort) begin
                    w_start     = 1'b1;
                    w_state_nxt = c_st_req;
                end
            end
            c_st_req: begin
                if (bus.abort || bus.ack_comb || w_timeout) begin
                    w_done      = 1'b1;
                    w_state_nxt = c_st_idle;
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State, one-hot request and index registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
            r_req   <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start) begin
                r_req <= NUM_WORDS'(1) << w_idx;
                r_idx <= w_idx;
            end else if (w_done) begin
                // Index is returned to 0 so it reads 0 whenever idle.
                r_req <= '0;
                r_idx <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Acknowledge wait counter and timeout
    // ------------------------------------------------------------------
    generate
        if (NEED_EXTERNAL_ACK != 0 && ACK_TIMEOUT != 0) begin : g_timeout
            localparam logic [CNT_WIDTH-1:0] c_cnt_last = CNT_WIDTH'(ACK_TIMEOUT - 1);
            localparam logic [CNT_WIDTH-1:0] c_cnt_max  = CNT_WIDTH'(ACK_TIMEOUT);

            logic [CNT_WIDTH-1:0] r_cnt;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_cnt <= '0;
                end else if (w_start) begin
                    r_cnt <= '0;
                end else if (w_busy && !bus.external_ack && (r_cnt != c_cnt_max)) begin
                    r_cnt <= r_cnt + CNT_WIDTH'(1);
                end
            end

            // The counter holds the number of completed wait cycles, so the
            // ACK_TIMEOUT-th REQ cycle is the one that sees ACK_TIMEOUT-1.
            assign w_timeout = w_busy && !bus.external_ack && (r_cnt == c_cnt_last);
        end else begin : g_no_timeout
            assign w_timeout = 1'b0;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    generate
        if (NEED_EXTERNAL_ACK == 0) begin : g_ack_immediate
            assign bus.qualified_ack = w_busy;
        end else begin : g_ack_external
            // Combinational path from external_ack so the word logic can
            // complete in the same cycle it asserts its ack.
            assign bus.qualified_ack = w_busy && (bus.external_ack || w_timeout);
        end
    endgenerate

    assign bus.qualified_req = r_req;
    assign bus.qualified_idx = r_idx;
    assign bus.timeout_err   = w_timeout;
    assign bus.busy          = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_slave_range_access.sv
`default_nettype none
// ============================================================================
// Module      : tb_slave_range_access
// Description : Testbench for slave_range_access. Three instances share one
//               stimulus stream: immediate-ack window at 0x10, external-ack
//               window at 0x10 with a 4-cycle timeout, and immediate-ack
//               window at the top of the address space (0xFFFC). Each output
//               of each instance is compared every cycle against a behavioural
//               model of the access rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_slave_range_access;

    localparam int P_BASE [3] = '{'h0010, 'h0010, 'hFFFC};
    localparam int P_EXT  [3] = '{0, 1, 0};
    localparam int P_TMO  [3] = '{16, 4, 16};

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] address;
    logic        request;
    logic        ack_comb;
    logic        abort;
    logic        external_ack;

    int n_asserts = 0;
    int n_fail    = 0;
    int cyc       = 0;

    always #5 clk = ~clk;

    slave_range_access_if #(.ADDR_WIDTH(16), .NUM_WORDS(4)) bus_a ();
    slave_range_access_if #(.ADDR_WIDTH(16), .NUM_WORDS(4)) bus_b ();
    slave_range_access_if #(.ADDR_WIDTH(16), .NUM_WORDS(4)) bus_c ();

    slave_range_access #(
        .ADDR_WIDTH(16), .BASE_ADDR(16'h0010), .NUM_WORDS(4),
        .NEED_EXTERNAL_ACK(0), .ACK_TIMEOUT(16)
    ) dut_imm (.clk(clk), .rst(rst), .bus(bus_a));

    slave_range_access #(
        .ADDR_WIDTH(16), .BASE_ADDR(16'h0010), .NUM_WORDS(4),
        .NEED_EXTERNAL_ACK(1), .ACK_TIMEOUT(4)
    ) dut_ext (.clk(clk), .rst(rst), .bus(bus_b));

    slave_range_access #(
        .ADDR_WIDTH(16), .BASE_ADDR(16'hFFFC), .NUM_WORDS(4),
        .NEED_EXTERNAL_ACK(0), .ACK_TIMEOUT(16)
    ) dut_top (.clk(clk), .rst(rst), .bus(bus_c));

    assign bus_a.address = address;  assign bus_b.address = address;  assign bus_c.address = address;
    assign bus_a.request = request;  assign bus_b.request = request;  assign bus_c.request = request;
    assign bus_a.ack_comb = ack_comb; assign bus_b.ack_comb = ack_comb; assign bus_c.ack_comb = ack_comb;
    assign bus_a.abort = abort;      assign bus_b.abort = abort;      assign bus_c.abort = abort;
    assign bus_a.external_ack = external_ack;
    assign bus_b.external_ack = external_ack;
    assign bus_c.external_ack = external_ack;

    logic [3:0] o_req  [3];
    logic [1:0] o_idx  [3];
    logic       o_ack  [3];
    logic       o_tmo  [3];
    logic       o_busy [3];

    assign o_req[0] = bus_a.qualified_req; assign o_idx[0] = bus_a.qualified_idx;
    assign o_ack[0] = bus_a.qualified_ack; assign o_tmo[0] = bus_a.timeout_err;
    assign o_busy[0] = bus_a.busy;
    assign o_req[1] = bus_b.qualified_req; assign o_idx[1] = bus_b.qualified_idx;
    assign o_ack[1] = bus_b.qualified_ack; assign o_tmo[1] = bus_b.timeout_err;
    assign o_busy[1] = bus_b.busy;
    assign o_req[2] = bus_c.qualified_req; assign o_idx[2] = bus_c.qualified_idx;
    assign o_ack[2] = bus_c.qualified_ack; assign o_tmo[2] = bus_c.timeout_err;
    assign o_busy[2] = bus_c.busy;

    // Reference model: is an access in progress, which word, and how many
    // REQ cycles have passed without external_ack.
    bit m_busy [3];
    int m_idx  [3];
    int m_wait [3];

    function automatic bit in_window(input int d, input logic [15:0] a);
        int ai;
        ai = int'(a);
        return (ai >= P_BASE[d]) && (ai < P_BASE[d] + 4);
    endfunction

    function automatic bit exp_timeout(input int d);
        return m_busy[d] && (P_EXT[d] != 0) && (P_TMO[d] != 0) &&
               !external_ack && (m_wait[d] == P_TMO[d] - 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int d = 0; d < 3; d++) begin
            bit         tmo_e;
            bit         ack_e;
            logic [3:0] req_e;
            logic [1:0] idx_e;
            tmo_e = exp_timeout(d);
            ack_e = m_busy[d] && ((P_EXT[d] == 0) || external_ack || tmo_e);
            req_e = m_busy[d] ? 4'(1 << m_idx[d]) : 4'd0;
            idx_e = m_busy[d] ? 2'(m_idx[d]) : 2'd0;
            chk($sformatf("d%0d_c%0d_req", d, cyc), 32'(o_req[d]), 32'(req_e));
            chk($sformatf("d%0d_c%0d_idx", d, cyc), 32'(o_idx[d]), 32'(idx_e));
            chk($sformatf("d%0d_c%0d_ack", d, cyc), 32'(o_ack[d]), 32'(ack_e));
            chk($sformatf("d%0d_c%0d_tmo", d, cyc), 32'(o_tmo[d]), 32'(tmo_e));
            chk($sformatf("d%0d_c%0d_busy", d, cyc), 32'(o_busy[d]), 32'(m_busy[d]));
        end
    endtask

    task automatic model_edge();
        for (int d = 0; d < 3; d++) begin
            bit tmo_e;
            tmo_e = exp_timeout(d);
            if (rst) begin
                m_busy[d] = 1'b0;
                m_idx[d]  = 0;
                m_wait[d] = 0;
            end else if (m_busy[d]) begin
                if (abort || ack_comb || tmo_e) m_busy[d] = 1'b0;
                else if (!external_ack) m_wait[d]++;
            end else if (request && in_window(d, address) && !ack_comb && !abort) begin
                m_busy[d] = 1'b1;
                m_idx[d]  = int'(address) - P_BASE[d];
                m_wait[d] = 0;
            end
        end
    endtask

    // One bus cycle: compare outputs mid-cycle, then advance the model
    // across the rising edge with the same inputs the DUT sampled.
    task automatic step();
        @(negedge clk);
        check_all();
        @(posedge clk);
        model_edge();
        #1;
        cyc++;
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            m_busy[d] = 1'b0; m_idx[d] = 0; m_wait[d] = 0;
        end
        rst = 1'b1; address = '0; request = 1'b0; ack_comb = 1'b0;
        abort = 1'b0; external_ack = 1'b0;
        @(posedge clk); #1;

        // Reset state
        step(); step();
        rst = 1'b0;
        step();

        // Immediate hit on word 2, then bus ack ends it
        request = 1'b1; address = 16'h0012; step();
        request = 1'b0; ack_comb = 1'b1; step();
        ack_comb = 1'b0; step(); step();

        // Misses on both sides of the window, and no wrap at the top window
        request = 1'b1; address = 16'h0014; step(); step();
        address = 16'h000F; step(); step();
        address = 16'h0000; step(); step();
        request = 1'b0; step();

        // Last word of the top window
        request = 1'b1; address = 16'hFFFF; step();
        request = 1'b0; ack_comb = 1'b1; step();
        ack_comb = 1'b0; step();

        // External ack in the third REQ cycle
        request = 1'b1; address = 16'h0011; step();
        request = 1'b0; step(); step();
        external_ack = 1'b1; ack_comb = 1'b1; step();
        external_ack = 1'b0; ack_comb = 1'b0; step(); step();

        // Timeout with no external ack
        request = 1'b1; address = 16'h0013; step();
        request = 1'b0; repeat (6) step();
        ack_comb = 1'b1; step();
        ack_comb = 1'b0; step();

        // Abort in the second REQ cycle with external_ack and request held
        request = 1'b1; address = 16'h0010; step();
        step();
        external_ack = 1'b1; abort = 1'b1; step();
        step(); step();
        abort = 1'b0; external_ack = 1'b0; request = 1'b0; step();
        ack_comb = 1'b1; step();
        ack_comb = 1'b0; step();

        // Reset mid-access, then a fresh access times out on schedule
        request = 1'b1; address = 16'h0012; step();
        request = 1'b0; step();
        rst = 1'b1; step();
        rst = 1'b0; step();
        request = 1'b1; address = 16'h0013; step();
        request = 1'b0; repeat (5) step();
        ack_comb = 1'b1; step();
        ack_comb = 1'b0; step();

        // Randomised traffic
        repeat (400) begin
            rst          = ($urandom_range(0, 59) == 0);
            request      = ($urandom_range(0, 2) != 0);
            case ($urandom_range(0, 3))
                0:       address = 16'(16'h000E + $urandom_range(0, 7));
                1:       address = 16'(16'hFFFA + $urandom_range(0, 5));
                2:       address = 16'(16'h0010 + $urandom_range(0, 3));
                default: address = 16'($urandom);
            endcase
            ack_comb     = ($urandom_range(0, 3) == 0);
            abort        = ($urandom_range(0, 11) == 0);
            external_ack = ($urandom_range(0, 4) == 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
